// File: rtl/spart_mem_responder.sv
// SPART memory-side responder: word-addressed RAM answering one request per handshake after WAIT_CYCLES.
// Optional SPART_MEM_RESP_STATS_EN adds saturating rd_count/wr_count outputs.
module spart_mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] mem_data_addr1,
    input  logic [31:0] mem_data_wr1,
    input  logic        mem_rw_data1,
    input  logic        mem_valid_data1,
    output logic [31:0] mem_data_rd1,
    output logic        mem_ready_data1,
    output logic        addr_err
`ifdef SPART_MEM_RESP_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [27:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic [31:0]         rd_q;
    logic                ready_q;
    logic                err_q;

    logic [27:0]           req_addr;
    logic                  req_rw;
    logic                  req_oor;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  enter_resp;
    logic                  ram_we;

    logic [31:0] ram [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid_data1) begin
                    addr_d  = mem_data_addr1;
                    wdata_d = mem_data_wr1;
                    rw_d    = mem_rw_data1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_DRAIN;
            S_DRAIN: if (!mem_valid_data1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, so the read must use the live inputs.
    assign req_addr   = (state_q == S_IDLE) ? mem_data_addr1 : addr_q;
    assign req_rw     = (state_q == S_IDLE) ? mem_rw_data1 : rw_q;
    assign req_oor    = (req_addr >> DEPTH_LOG2) != '0;
    assign req_idx    = req_addr[DEPTH_LOG2-1:0];
    assign enter_resp = (state_d == S_RESP);
    assign ram_we     = (state_q == S_RESP) && rw_q && ((addr_q >> DEPTH_LOG2) == '0);

    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            ready_q <= enter_resp;
            if (enter_resp && !req_rw) rd_q <= req_oor ? ERR_PATTERN : ram[req_idx];
            if (enter_resp && req_oor) err_q <= 1'b1;
        end
    end

`ifdef SPART_MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (rw_q && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (!rw_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

    assign mem_data_rd1    = rd_q;
    assign mem_ready_data1 = ready_q;
    assign addr_err        = err_q;

endmodule

// File: tb/tb_spart_mem_responder.sv
// Randomized self-checking bench for spart_mem_responder against a request-level model.
module tb_spart_mem_responder;

    localparam int unsigned W    = 4;
    localparam int unsigned DL   = 10;
    localparam logic [31:0] ERRP = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] addr = '0, addr0 = '0;
    logic [31:0] wd = '0, wd0 = '0;
    logic        rw = 1'b0, rw0 = 1'b0, valid = 1'b0, valid0 = 1'b0;
    logic [31:0] rd, rd0;
    logic        ready, ready0, err, err0;
`ifdef SPART_MEM_RESP_STATS_EN
    logic [15:0] rdc, wrc, rdc0, wrc0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int pulses = 0;

    always #5 clk = ~clk;

    spart_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W), .ERR_PATTERN(ERRP)) u_dut (
        .clk(clk), .rst(rst),
        .mem_data_addr1(addr), .mem_data_wr1(wd), .mem_rw_data1(rw), .mem_valid_data1(valid),
        .mem_data_rd1(rd), .mem_ready_data1(ready), .addr_err(err)
`ifdef SPART_MEM_RESP_STATS_EN
        , .rd_count(rdc), .wr_count(wrc)
`endif
    );

    spart_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0), .ERR_PATTERN(ERRP)) u_dut0 (
        .clk(clk), .rst(rst),
        .mem_data_addr1(addr0), .mem_data_wr1(wd0), .mem_rw_data1(rw0), .mem_valid_data1(valid0),
        .mem_data_rd1(rd0), .mem_ready_data1(ready0), .addr_err(err0)
`ifdef SPART_MEM_RESP_STATS_EN
        , .rd_count(rdc0), .wr_count(wrc0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model of the WAIT_CYCLES=4 responder.
    logic [31:0] mem [int];
    bit          m_busy = 0, m_ready = 0, m_drain = 0;
    int          m_due = 0;
    logic [27:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    bit          m_rw = 0;
    logic [31:0] exp_rd = '0;
    bit          exp_err = 0;
    logic [15:0] exp_rdc = '0, exp_wrc = '0;

    function automatic bit oor(input logic [27:0] a);
        return (a >> DL) != 0;
    endfunction

    function void complete();
        m_busy  = 0;
        m_ready = 1;
        if (oor(m_addr)) exp_err = 1;
        if (!m_rw) begin
            if (oor(m_addr)) exp_rd = ERRP;
            else if (mem.exists(int'(m_addr))) exp_rd = mem[int'(m_addr)];
            else exp_rd = 'x;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_ready = 0; m_drain = 0;
            exp_rd = '0; exp_err = 0; exp_rdc = '0; exp_wrc = '0;
        end else if (m_ready) begin
            if (m_rw && !oor(m_addr)) mem[int'(m_addr)] = m_wd;
            if (m_rw) begin
                if (exp_wrc != 16'hFFFF) exp_wrc++;
            end else if (exp_rdc != 16'hFFFF) exp_rdc++;
            m_ready = 0;
            m_drain = 1;
        end else if (m_busy) begin
            m_due--;
            if (m_due == 0) complete();
        end else if (m_drain) begin
            if (!valid) m_drain = 0;
        end else if (valid) begin
            m_addr = addr; m_wd = wd; m_rw = rw;
            if (W == 0) complete();
            else begin
                m_busy = 1;
                m_due  = W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (ready) pulses++;
            if (!rst) begin
                chk("rst_ready", {31'b0, ready}, 32'd0);
                chk("rst_rd", rd, 32'd0);
                chk("rst_err", {31'b0, err}, 32'd0);
            end else begin
                chk("ready", {31'b0, ready}, {31'b0, m_ready});
                chk("addr_err", {31'b0, err}, {31'b0, exp_err});
                if (!$isunknown(exp_rd)) chk("rd", rd, exp_rd);
            end
`ifdef SPART_MEM_RESP_STATS_EN
            chk("rd_count", {16'b0, rdc}, rst ? {16'b0, exp_rdc} : 32'd0);
            chk("wr_count", {16'b0, wrc}, rst ? {16'b0, exp_wrc} : 32'd0);
`endif
        end
    end

    task automatic do_req(input bit sel, input logic [27:0] a, input logic [31:0] d, input bit w,
                          input bit early, input int extra,
                          output int lat, output logic [31:0] rd_s, output logic err_s);
        lat = 0;
        @(posedge clk); #2;
        if (sel) begin addr0 = a; wd0 = d; rw0 = w; valid0 = 1'b1; end
        else begin addr = a; wd = d; rw = w; valid = 1'b1; end
        @(posedge clk); #2;
        if (early) begin
            if (sel) valid0 = 1'b0; else valid = 1'b0;
        end else if (sel) begin
            addr0 = 28'($urandom); wd0 = $urandom; rw0 = ~w;
        end else begin
            addr = 28'($urandom); wd = $urandom; rw = ~w;
        end
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? ready0 : ready) && lat < 40);
        chk(sel ? "ready0_seen" : "ready_seen", {31'b0, sel ? ready0 : ready}, 32'd1);
        rd_s  = sel ? rd0 : rd;
        err_s = sel ? err0 : err;
        repeat (extra) @(posedge clk);
        @(posedge clk); #2;
        if (sel) valid0 = 1'b0; else valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rs;
        logic        es;
        int          p0;

        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            logic [27:0] a;
            a = (i < 16) ? 28'(i) : 28'h3FF;
            do_req(0, a, 32'hC0DE_0000 | 32'(a), 1, 0, 0, lat, rs, es);
        end

        do_req(0, 28'h5, 32'h1234_5678, 1, 0, 0, lat, rs, es);
        chk("wr5_lat", 32'(lat), 32'd5);
        do_req(0, 28'h5, 32'h0, 0, 0, 0, lat, rs, es);
        chk("rd5_lat", 32'(lat), 32'd5);
        chk("rd5_data", rs, 32'h1234_5678);
        chk("rd5_err", {31'b0, es}, 32'd0);

        do_req(0, 28'h400, 32'h1, 1, 0, 0, lat, rs, es);
        chk("oor_wr_err", {31'b0, es}, 32'd1);
        do_req(0, 28'h400, 32'h0, 0, 0, 0, lat, rs, es);
        chk("oor_rd_data", rs, 32'hDEAD_BEEF);
        chk("oor_rd_err", {31'b0, es}, 32'd1);
        do_req(0, 28'h0, 32'h0, 0, 0, 0, lat, rs, es);
        chk("ram0_kept", rs, 32'hC0DE_0000);
        chk("err_sticky", {31'b0, es}, 32'd1);

        @(posedge clk); #2;
        addr = 28'h7; wd = 32'hFFFF_FFFF; rw = 1'b1; valid = 1'b1;
        @(posedge clk); #2 valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        do_req(0, 28'h7, 32'h0, 0, 0, 0, lat, rs, es);
        chk("rst_abort_lat", 32'(lat), 32'd5);
        chk("rst_abort_data", rs, 32'hC0DE_0007);
        chk("rst_abort_err", {31'b0, es}, 32'd0);

        p0 = pulses;
        do_req(0, 28'h3, 32'h0, 0, 0, 20, lat, rs, es);
        chk("held_pulses", 32'(pulses - p0), 32'd1);
        chk("held_data", rs, 32'hC0DE_0003);
        do_req(0, 28'h5, 32'h0, 0, 1, 0, lat, rs, es);
        chk("early_lat", 32'(lat), 32'd5);
        chk("early_data", rs, 32'h1234_5678);

        for (int n = 0; n < 150; n++) begin
            int          r;
            logic [27:0] a;
            r = $urandom_range(0, 19);
            if (r < 16) a = 28'(r);
            else if (r == 16) a = 28'h3FF;
            else if (r == 17) a = 28'h400;
            else if (r == 18) a = 28'hFFF_FFFF;
            else a = 28'h001_0000 | 28'($urandom_range(0, 1023));
            do_req(0, a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3), lat, rs, es);
            chk("rand_lat", 32'(lat), W + 1);
        end

        do_req(1, 28'h3FF, 32'hA5A5_A5A5, 1, 0, 0, lat, rs, es);
        chk("w0_wr_lat", 32'(lat), 32'd1);
        do_req(1, 28'h3FF, 32'h0, 0, 0, 0, lat, rs, es);
        chk("w0_rd_lat", 32'(lat), 32'd1);
        chk("w0_rd_data", rs, 32'hA5A5_A5A5);
        chk("w0_rd_err", {31'b0, es}, 32'd0);
        do_req(1, 28'h800, 32'h0, 0, 1, 0, lat, rs, es);
        chk("w0_oor_data", rs, 32'hDEAD_BEEF);
        chk("w0_oor_err", {31'b0, es}, 32'd1);
`ifdef SPART_MEM_RESP_STATS_EN
        @(negedge clk);
        chk("w0_wr_count", {16'b0, wrc0}, 32'd1);
        chk("w0_rd_count", {16'b0, rdc0}, 32'd2);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
